// File: rtl/reg_op_sequencer_pkg.sv
// Shared types and widths for the register-operation sequencer and its phase timer.
package reg_op_sequencer_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_OP_W   = 4;
  localparam int unsigned FLAG_W     = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RR   = 2'd1,
    S_F    = 2'd2,
    S_WB   = 2'd3
  } state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] ra;
    logic [REG_ADDR_W-1:0] rb;
    logic [REG_ADDR_W-1:0] wa;
    logic [ALU_OP_W-1:0]   op;
    logic                  we;
  } cmd_t;

endpackage

// File: rtl/reg_op_sequencer_phase_timer.sv
// Loadable down-counter that times each sequencer phase; saturates at zero.
module phase_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/reg_op_sequencer.sv
// Command-driven RR/F/WB phase sequencer: latches one register operation per
// handshake and emits registered one-cycle phase strobes to the datapath.
module reg_op_sequencer
  import reg_op_sequencer_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Cmd_Valid,
  output logic                  Cmd_Ready,
  input  logic [REG_ADDR_W-1:0] Cmd_RA,
  input  logic [REG_ADDR_W-1:0] Cmd_RB,
  input  logic [REG_ADDR_W-1:0] Cmd_WA,
  input  logic [ALU_OP_W-1:0]   Cmd_OP,
  input  logic                  Cmd_WE,
  input  logic                  Abort,
  output logic [REG_ADDR_W-1:0] R_Addr_A,
  output logic [REG_ADDR_W-1:0] R_Addr_B,
  output logic [REG_ADDR_W-1:0] W_Addr,
  output logic [ALU_OP_W-1:0]   ALU_OP,
  output logic                  Reg_Write,
  output logic                  RR_Stb,
  output logic                  F_Stb,
  output logic                  WB_Stb,
  input  logic [FLAG_W-1:0]     FR,
  output logic [FLAG_W-1:0]     Last_FR,
  output logic                  Done,
  output logic [CNT_W-1:0]      Op_Cnt
);

  localparam int unsigned  TW     = $clog2(PHASE_CYCLES + 1);
  localparam logic [TW-1:0] RELOAD = TW'(PHASE_CYCLES - 1);

  state_t state;
  cmd_t   cmd_q;
  logic   wb_first;
  logic   accept;
  logic   tmr_load;
  logic   tmr_zero;

  assign Cmd_Ready = (state == S_IDLE);
  assign accept    = Cmd_Valid && Cmd_Ready;

  always_comb begin
    tmr_load = accept || ((state != S_IDLE) && tmr_zero);
  end

  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (RELOAD),
    .zero     (tmr_zero)
  );

  // Strobes are set on the edge that enters a phase, so each is high for
  // exactly the first cycle of that phase and is cleared by default.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cmd_q    <= '0;
      wb_first <= 1'b0;
      RR_Stb   <= 1'b0;
      F_Stb    <= 1'b0;
      WB_Stb   <= 1'b0;
      Done     <= 1'b0;
      Last_FR  <= '0;
      Op_Cnt   <= '0;
    end else begin
      RR_Stb   <= 1'b0;
      F_Stb    <= 1'b0;
      WB_Stb   <= 1'b0;
      Done     <= 1'b0;
      wb_first <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (Cmd_Valid) begin
            cmd_q  <= '{ra: Cmd_RA, rb: Cmd_RB, wa: Cmd_WA, op: Cmd_OP, we: Cmd_WE};
            state  <= S_RR;
            RR_Stb <= 1'b1;
          end
        end
        S_RR: begin
          if (Abort) begin
            state <= S_IDLE;
          end else if (tmr_zero) begin
            state <= S_F;
            F_Stb <= 1'b1;
          end
        end
        S_F: begin
          if (Abort) begin
            state <= S_IDLE;
          end else if (tmr_zero) begin
            state    <= S_WB;
            WB_Stb   <= cmd_q.we;
            wb_first <= 1'b1;
          end
        end
        S_WB: begin
          if (wb_first) begin
            Last_FR <= FR;
          end
          if (tmr_zero) begin
            state <= S_IDLE;
            Done  <= 1'b1;
            if (cmd_q.we) begin
              Op_Cnt <= Op_Cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign R_Addr_A  = cmd_q.ra;
  assign R_Addr_B  = cmd_q.rb;
  assign W_Addr    = cmd_q.wa;
  assign ALU_OP    = cmd_q.op;
  assign Reg_Write = cmd_q.we;

endmodule
